// File: rtl/tiny_rv_exec_m.sv
// Execute stage: one-cycle ALU/LUI/AUIPC/JAL/JALR/branch resolution plus an
// optional iterative RV M-extension multiply/divide unit.
module tiny_rv_exec_m #(
  parameter int XLEN              = 32,
  parameter int ENABLE_M          = 1,
  parameter int MD_BITS_PER_CYCLE = 1
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            rr_valid,
  input  logic [XLEN-1:0] rr_pc,
  input  logic [31:0]     rr_inst,
  input  logic [6:0]      rr_opcode,
  input  logic [4:0]      rr_rd,
  input  logic [XLEN-1:0] rr_rs1,
  input  logic [XLEN-1:0] rr_rs2,
  input  logic [2:0]      rr_funct3,
  input  logic [6:0]      rr_funct7,
  input  logic [XLEN-1:0] rr_imm32,
  input  logic            mem_exec_stall,
  output logic            exec_rr_stall,
  output logic            exec_rr_flush,
  output logic            exec_valid,
  output logic [XLEN-1:0] exec_pc,
  output logic [31:0]     exec_inst,
  output logic [4:0]      exec_rd,
  output logic [XLEN-1:0] exec_rd_val,
  output logic            exec_illegal,
  output logic [XLEN-1:0] new_pc,
  output logic            ld_new_pc
);

  localparam int SHW  = $clog2(XLEN);
  localparam int ITER = XLEN / MD_BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER) + 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [XLEN-1:0] MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] LSB_CLEAR = {{(XLEN-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

  md_state_t md_state, md_state_next;

  logic [XLEN-1:0] md_hi, md_lo, md_b, md_pc;
  logic [31:0]     md_inst;
  logic [4:0]      md_rd;
  logic [2:0]      md_f3;
  logic            md_neg, md_neg_r;
  logic [CW-1:0]   md_cnt;

  logic            accept, md_start;
  logic [XLEN-1:0] op2, alu_val, sc_val, redirect_pc, pc_plus4;
  logic [SHW-1:0]  shamt;
  logic [6:0]      shift_f7;
  logic            br_eq, br_lt, br_ltu;
  logic            sc_illegal, redirect, is_branch, md_iter;
  logic            md_a_signed, md_b_signed, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN-1:0] step_hi, step_lo;
  logic [XLEN:0]   sum, trial;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] md_res;

  assign exec_rr_stall = mem_exec_stall | (md_state != MD_IDLE);
  assign accept        = rr_valid & ~exec_rr_stall;
  assign md_start      = accept & md_iter;
  assign ld_new_pc     = accept & redirect;
  assign exec_rr_flush = ld_new_pc;
  assign new_pc        = redirect_pc;
  assign pc_plus4      = rr_pc + {{(XLEN-3){1'b0}}, 3'd4};

  // Decode, single-cycle result, redirect and M special cases
  always_comb begin
    op2         = (rr_opcode == OPC_OP_IMM) ? rr_imm32 : rr_rs2;
    shamt       = op2[SHW-1:0];
    shift_f7    = (XLEN == 64) ? {rr_funct7[6:1], 1'b0} : rr_funct7;
    br_eq       = (rr_rs1 == rr_rs2);
    br_lt       = ($signed(rr_rs1) < $signed(rr_rs2));
    br_ltu      = (rr_rs1 < rr_rs2);
    alu_val     = '0;
    sc_val      = '0;
    sc_illegal  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = rr_pc + rr_imm32;
    is_branch   = 1'b0;
    md_iter     = 1'b0;

    case (rr_funct3)
      3'b000:  alu_val = (rr_opcode == OPC_OP && rr_funct7[5]) ? rr_rs1 - op2 : rr_rs1 + op2;
      3'b001:  alu_val = rr_rs1 << shamt;
      3'b010:  alu_val = {{(XLEN-1){1'b0}}, ($signed(rr_rs1) < $signed(op2))};
      3'b011:  alu_val = {{(XLEN-1){1'b0}}, (rr_rs1 < op2)};
      3'b100:  alu_val = rr_rs1 ^ op2;
      3'b101:  alu_val = rr_funct7[5] ? XLEN'($signed(rr_rs1) >>> shamt) : rr_rs1 >> shamt;
      3'b110:  alu_val = rr_rs1 | op2;
      default: alu_val = rr_rs1 & op2;
    endcase

    case (rr_opcode)
      OPC_LUI:   sc_val = rr_imm32;
      OPC_AUIPC: sc_val = rr_pc + rr_imm32;
      OPC_JAL: begin
        sc_val   = pc_plus4;
        redirect = 1'b1;
      end
      OPC_JALR: begin
        if (rr_funct3 == 3'b000) begin
          sc_val      = pc_plus4;
          redirect    = 1'b1;
          redirect_pc = (rr_rs1 + rr_imm32) & LSB_CLEAR;
        end else begin
          sc_illegal = 1'b1;
        end
      end
      OPC_BRANCH: begin
        is_branch = 1'b1;
        case (rr_funct3)
          3'b000:  redirect = br_eq;
          3'b001:  redirect = ~br_eq;
          3'b100:  redirect = br_lt;
          3'b101:  redirect = ~br_lt;
          3'b110:  redirect = br_ltu;
          3'b111:  redirect = ~br_ltu;
          default: sc_illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        if (rr_funct3 == 3'b001 && shift_f7 != 7'b0000000)
          sc_illegal = 1'b1;
        else if (rr_funct3 == 3'b101 && shift_f7 != 7'b0000000 && shift_f7 != 7'b0100000)
          sc_illegal = 1'b1;
        else
          sc_val = alu_val;
      end
      OPC_OP: begin
        if (rr_funct7 == 7'b0000000) begin
          sc_val = alu_val;
        end else if (rr_funct7 == 7'b0100000 && (rr_funct3 == 3'b000 || rr_funct3 == 3'b101)) begin
          sc_val = alu_val;
        end else if (rr_funct7 == 7'b0000001 && ENABLE_M != 0) begin
          // Divide-by-zero and signed overflow resolve here without the FSM
          if (!rr_funct3[2])
            md_iter = 1'b1;
          else if (rr_rs2 == '0)
            sc_val = rr_funct3[1] ? rr_rs1 : '1;
          else if (!rr_funct3[0] && rr_rs1 == MIN_INT && rr_rs2 == '1)
            sc_val = rr_funct3[1] ? '0 : MIN_INT;
          else
            md_iter = 1'b1;
        end else begin
          sc_illegal = 1'b1;
        end
      end
      default: sc_illegal = 1'b1;
    endcase
  end

  // Operand magnitudes and result signs captured when an M op starts
  always_comb begin
    md_a_signed = rr_funct3[2] ? ~rr_funct3[0]
                               : (rr_funct3[1:0] == 2'b01 || rr_funct3[1:0] == 2'b10);
    md_b_signed = rr_funct3[2] ? ~rr_funct3[0] : (rr_funct3[1:0] == 2'b01);
    neg_a       = md_a_signed & rr_rs1[XLEN-1];
    neg_b       = md_b_signed & rr_rs2[XLEN-1];
    mag_a       = neg_a ? -rr_rs1 : rr_rs1;
    mag_b       = neg_b ? -rr_rs2 : rr_rs2;
  end

  // One cycle of shift-add multiply or restoring divide
  always_comb begin
    step_hi = md_hi;
    step_lo = md_lo;
    sum     = '0;
    trial   = '0;
    for (int i = 0; i < MD_BITS_PER_CYCLE; i++) begin
      if (!md_f3[2]) begin
        sum     = {1'b0, step_hi} + (step_lo[0] ? {1'b0, md_b} : '0);
        step_lo = {sum[0], step_lo[XLEN-1:1]};
        step_hi = sum[XLEN:1];
      end else begin
        trial   = {step_hi, step_lo[XLEN-1]};
        step_lo = {step_lo[XLEN-2:0], 1'b0};
        if (trial >= {1'b0, md_b}) begin
          trial      = trial - {1'b0, md_b};
          step_lo[0] = 1'b1;
        end
        step_hi = trial[XLEN-1:0];
      end
    end
  end

  always_comb begin
    prod     = {md_hi, md_lo};
    prod_fix = md_neg ? -prod : prod;
    case (md_f3)
      3'b000:        md_res = prod_fix[XLEN-1:0];
      3'b100, 3'b101: md_res = md_neg ? -md_lo : md_lo;
      3'b110, 3'b111: md_res = md_neg_r ? -md_hi : md_hi;
      default:       md_res = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) md_state <= MD_IDLE;
    else            md_state <= md_state_next;
  end

  always_comb begin
    md_state_next = md_state;
    case (md_state)
      MD_IDLE: if (md_start) md_state_next = MD_BUSY;
      MD_BUSY: if (md_cnt == CW'(ITER - 1)) md_state_next = MD_DONE;
      MD_DONE: if (!mem_exec_stall) md_state_next = MD_IDLE;
      default: md_state_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      md_hi    <= '0;
      md_lo    <= '0;
      md_b     <= '0;
      md_pc    <= '0;
      md_inst  <= '0;
      md_rd    <= '0;
      md_f3    <= '0;
      md_neg   <= 1'b0;
      md_neg_r <= 1'b0;
      md_cnt   <= '0;
    end else if (md_start) begin
      md_hi    <= '0;
      md_lo    <= mag_a;
      md_b     <= mag_b;
      md_pc    <= rr_pc;
      md_inst  <= rr_inst;
      md_rd    <= rr_rd;
      md_f3    <= rr_funct3;
      md_neg   <= neg_a ^ neg_b;
      md_neg_r <= neg_a;
      md_cnt   <= '0;
    end else if (md_state == MD_BUSY) begin
      md_hi  <= step_hi;
      md_lo  <= step_lo;
      md_cnt <= md_cnt + 1'b1;
    end
  end

  // Output register: downstream stall freezes everything
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      exec_valid   <= 1'b0;
      exec_pc      <= '0;
      exec_inst    <= '0;
      exec_rd      <= '0;
      exec_rd_val  <= '0;
      exec_illegal <= 1'b0;
    end else if (!mem_exec_stall) begin
      if (md_state == MD_DONE) begin
        exec_valid   <= 1'b1;
        exec_pc      <= md_pc;
        exec_inst    <= md_inst;
        exec_rd      <= md_rd;
        exec_rd_val  <= (md_rd == 5'd0) ? '0 : md_res;
        exec_illegal <= 1'b0;
      end else if (accept && !md_iter) begin
        exec_valid   <= 1'b1;
        exec_pc      <= rr_pc;
        exec_inst    <= rr_inst;
        exec_rd      <= is_branch ? 5'd0 : rr_rd;
        exec_rd_val  <= (is_branch || rr_rd == 5'd0) ? '0 : sc_val;
        exec_illegal <= sc_illegal;
      end else begin
        exec_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tiny_rv_exec_m.sv
// Directed bench for tiny_rv_exec_m (XLEN=32, ENABLE_M=1, one bit per cycle).
module tb_tiny_rv_exec_m;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_M       = 7'b0000001;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rr_valid;
  logic [31:0] rr_pc, rr_inst, rr_rs1, rr_rs2, rr_imm32;
  logic [6:0]  rr_opcode, rr_funct7;
  logic [4:0]  rr_rd;
  logic [2:0]  rr_funct3;
  logic        mem_exec_stall;
  logic        exec_rr_stall, exec_rr_flush, exec_valid, exec_illegal, ld_new_pc;
  logic [31:0] exec_pc, exec_inst, exec_rd_val, new_pc;
  logic [4:0]  exec_rd;

  int assert_count = 0;
  int fail_count   = 0;
  int stall_cycles;

  tiny_rv_exec_m #(.XLEN(32), .ENABLE_M(1), .MD_BITS_PER_CYCLE(1)) dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .rr_valid(rr_valid), .rr_pc(rr_pc), .rr_inst(rr_inst), .rr_opcode(rr_opcode),
    .rr_rd(rr_rd), .rr_rs1(rr_rs1), .rr_rs2(rr_rs2), .rr_funct3(rr_funct3),
    .rr_funct7(rr_funct7), .rr_imm32(rr_imm32), .mem_exec_stall(mem_exec_stall),
    .exec_rr_stall(exec_rr_stall), .exec_rr_flush(exec_rr_flush), .exec_valid(exec_valid),
    .exec_pc(exec_pc), .exec_inst(exec_inst), .exec_rd(exec_rd), .exec_rd_val(exec_rd_val),
    .exec_illegal(exec_illegal), .new_pc(new_pc), .ld_new_pc(ld_new_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic [31:0] imm);
    rr_valid  = 1'b1;
    rr_opcode = opc;
    rr_funct3 = f3;
    rr_funct7 = f7;
    rr_rd     = rd;
    rr_pc     = pc;
    rr_rs1    = rs1;
    rr_rs2    = rs2;
    rr_imm32  = imm;
    rr_inst   = {f7, 5'd0, 5'd0, f3, rd, opc};
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one single-cycle op, then check the registered result
  task automatic runSingle(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] rd, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] exp_val);
    applyStimulus(opc, f3, f7, rd, 32'h300, rs1, rs2, imm);
    tick();
    rr_valid = 1'b0;
    checkOutput({tag, "_valid"}, 64'(exec_valid), 64'h1);
    checkOutput({tag, "_val"}, 64'(exec_rd_val), 64'(exp_val));
  endtask

  // Issue an iterative M op and count the cycles rr is held off
  task automatic runMulDiv(input string tag, input logic [2:0] f3, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [31:0] exp_val);
    applyStimulus(OPC_OP, f3, F7_M, 5'd3, 32'h400, rs1, rs2, 32'h0);
    tick();
    rr_valid = 1'b0;
    checkOutput({tag, "_busy_valid"}, 64'(exec_valid), 64'h0);
    stall_cycles = 0;
    while (exec_rr_stall && stall_cycles < 100) begin
      stall_cycles++;
      tick();
    end
    checkOutput({tag, "_stall_cycles"}, 64'(stall_cycles), 64'd33);
    checkOutput({tag, "_valid"}, 64'(exec_valid), 64'h1);
    checkOutput({tag, "_val"}, 64'(exec_rd_val), 64'(exp_val));
  endtask

  initial begin
    reset_n = 1'b0;
    mem_exec_stall = 1'b0;
    rr_valid = 1'b0;
    applyStimulus(OPC_OP_IMM, 3'b000, 7'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    rr_valid = 1'b0;
    tick();
    tick();
    checkOutput("reset_valid", 64'(exec_valid), 64'h0);
    checkOutput("reset_rd_val", 64'(exec_rd_val), 64'h0);
    checkOutput("reset_pc", 64'(exec_pc), 64'h0);
    checkOutput("reset_stall", 64'(exec_rr_stall), 64'h0);
    checkOutput("reset_ld_new_pc", 64'(ld_new_pc), 64'h0);
    reset_n = 1'b1;
    tick();

    $display("[TB] ADDI overflow wrap");
    applyStimulus(OPC_OP_IMM, 3'b000, 7'd0, 5'd5, 32'h10, 32'h7FFFFFFF, 32'h0, 32'h1);
    #1;
    checkOutput("addi_no_redirect", 64'(ld_new_pc), 64'h0);
    tick();
    checkOutput("addi_valid", 64'(exec_valid), 64'h1);
    checkOutput("addi_rd", 64'(exec_rd), 64'd5);
    checkOutput("addi_val", 64'(exec_rd_val), 64'h80000000);
    checkOutput("addi_illegal", 64'(exec_illegal), 64'h0);
    checkOutput("addi_pc", 64'(exec_pc), 64'h10);

    $display("[TB] downstream stall holds result and blocks redirect");
    mem_exec_stall = 1'b1;
    applyStimulus(OPC_BRANCH, 3'b000, 7'd0, 5'd7, 32'h100, 32'd3, 32'd3, 32'h20);
    #1;
    checkOutput("memstall_ld_new_pc", 64'(ld_new_pc), 64'h0);
    checkOutput("memstall_rr_stall", 64'(exec_rr_stall), 64'h1);
    tick();
    checkOutput("memstall_hold_valid", 64'(exec_valid), 64'h1);
    checkOutput("memstall_hold_val", 64'(exec_rd_val), 64'h80000000);
    mem_exec_stall = 1'b0;

    $display("[TB] branches");
    #1;
    checkOutput("beq_ld_new_pc", 64'(ld_new_pc), 64'h1);
    checkOutput("beq_flush", 64'(exec_rr_flush), 64'h1);
    checkOutput("beq_new_pc", 64'(new_pc), 64'h120);
    tick();
    checkOutput("beq_rd", 64'(exec_rd), 64'd0);
    checkOutput("beq_rd_val", 64'(exec_rd_val), 64'h0);
    applyStimulus(OPC_BRANCH, 3'b001, 7'd0, 5'd7, 32'h100, 32'd3, 32'd3, 32'h20);
    #1;
    checkOutput("bne_ld_new_pc", 64'(ld_new_pc), 64'h0);
    tick();
    applyStimulus(OPC_JALR, 3'b000, 7'd0, 5'd1, 32'h40, 32'h1001, 32'h0, 32'h2);
    #1;
    checkOutput("jalr_ld_new_pc", 64'(ld_new_pc), 64'h1);
    checkOutput("jalr_new_pc", 64'(new_pc), 64'h1002);
    tick();
    rr_valid = 1'b0;
    checkOutput("jalr_rd_val", 64'(exec_rd_val), 64'h44);
    tick();
    checkOutput("idle_valid", 64'(exec_valid), 64'h0);

    $display("[TB] ALU and immediate ops");
    runSingle("sub", OPC_OP, 3'b000, 7'b0100000, 5'd2, 32'd5, 32'd7, 32'h0, 32'hFFFFFFFE);
    runSingle("sra", OPC_OP, 3'b101, 7'b0100000, 5'd2, 32'h80000000, 32'd33, 32'h0, 32'hC0000000);
    runSingle("slt", OPC_OP, 3'b010, 7'd0, 5'd2, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h1);
    runSingle("sltu", OPC_OP, 3'b011, 7'd0, 5'd2, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0);
    runSingle("lui", OPC_LUI, 3'b000, 7'd0, 5'd2, 32'h0, 32'h0, 32'h12345000, 32'h12345000);
    runSingle("auipc", OPC_AUIPC, 3'b000, 7'd0, 5'd2, 32'h0, 32'h0, 32'h1000, 32'h1300);
    runSingle("rd0", OPC_OP_IMM, 3'b000, 7'd0, 5'd0, 32'h55, 32'h0, 32'h1, 32'h0);
    applyStimulus(7'b1111111, 3'b000, 7'd0, 5'd9, 32'h500, 32'h1, 32'h1, 32'h4);
    #1;
    checkOutput("illegal_ld_new_pc", 64'(ld_new_pc), 64'h0);
    tick();
    rr_valid = 1'b0;
    checkOutput("illegal_flag", 64'(exec_illegal), 64'h1);
    checkOutput("illegal_rd_val", 64'(exec_rd_val), 64'h0);

    $display("[TB] iterative multiply/divide");
    runMulDiv("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    runMulDiv("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    runMulDiv("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    runMulDiv("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    runMulDiv("mulh", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
    runMulDiv("divu", 3'b101, 32'd100, 32'd7, 32'd14);

    $display("[TB] divide special cases");
    runSingle("divu_by0", OPC_OP, 3'b101, F7_M, 5'd3, 32'd5, 32'd0, 32'h0, 32'hFFFFFFFF);
    checkOutput("divu_by0_stall", 64'(exec_rr_stall), 64'h0);
    runSingle("remu_by0", OPC_OP, 3'b111, F7_M, 5'd3, 32'd5, 32'd0, 32'h0, 32'd5);
    runSingle("div_ovf", OPC_OP, 3'b100, F7_M, 5'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    runSingle("rem_ovf", OPC_OP, 3'b110, F7_M, 5'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0);

    $display("[TB] reset while busy");
    applyStimulus(OPC_OP, 3'b100, F7_M, 5'd3, 32'h400, 32'd1000, 32'd3, 32'h0);
    tick();
    rr_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    checkOutput("busy_before_reset", 64'(exec_rr_stall), 64'h1);
    reset_n = 1'b0;
    tick();
    checkOutput("busy_reset_valid", 64'(exec_valid), 64'h0);
    checkOutput("busy_reset_stall", 64'(exec_rr_stall), 64'h0);
    reset_n = 1'b1;
    tick();
    checkOutput("after_reset_stall", 64'(exec_rr_stall), 64'h0);
    checkOutput("after_reset_valid", 64'(exec_valid), 64'h0);

    $display("[TB] downstream stall while result is done");
    applyStimulus(OPC_OP, 3'b000, F7_M, 5'd4, 32'h600, 32'd6, 32'd7, 32'h0);
    tick();
    rr_valid = 1'b0;
    mem_exec_stall = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    checkOutput("done_hold_valid", 64'(exec_valid), 64'h0);
    checkOutput("done_hold_stall", 64'(exec_rr_stall), 64'h1);
    mem_exec_stall = 1'b0;
    #1;
    checkOutput("done_release_stall", 64'(exec_rr_stall), 64'h1);
    tick();
    checkOutput("done_release_valid", 64'(exec_valid), 64'h1);
    checkOutput("done_release_val", 64'(exec_rd_val), 64'd42);
    checkOutput("done_release_rd", 64'(exec_rd), 64'd4);
    checkOutput("done_release_pc", 64'(exec_pc), 64'h600);
    checkOutput("done_idle_stall", 64'(exec_rr_stall), 64'h0);
    tick();
    checkOutput("done_next_valid", 64'(exec_valid), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
